slice_serial_adder_ctrl: RTL and testbench



---
 rtl/slice_serial_adder_ctrl.sv | 115 +++++++++++
 tb/tb_slice_serial_adder_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/slice_serial_adder_ctrl.sv
// Digit-serial add/subtract sequencer: one shared 3-bit slice adder walks the operands
// LSB slice first and holds the result behind a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a new operation; in_ready high
// RUN   | one slice per cycle through the shared adder; busy high
// DONE  | result held; out_valid raised one cycle after entry, cleared on out_ready
module slice_serial_adder_ctrl #(
  parameter int SLICES = 4,
  parameter int IDXW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*SLICES-1:0]   in_a,
  input  logic [3*SLICES-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*SLICES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic                  busy,
  output logic [IDXW-1:0]       slice_idx
);

  localparam int W = 3 * SLICES;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           carry;
  logic [2:0]     a3;
  logic [2:0]     b3;
  logic [3:0]     slice_res;
  logic [W-1:0]   sum_next;
  logic           last_slice;

  // Slice select and write-back, plus the single shared slice adder.
  always_comb begin
    a3       = '0;
    b3       = '0;
    for (int k = 0; k < SLICES; k++) begin
      if (slice_idx == IDXW'(k)) begin
        a3 = op_a[3*k +: 3];
        b3 = op_b[3*k +: 3];
      end
    end
    slice_res = {1'b0, a3} + {1'b0, b3} + {3'b000, carry};
    sum_next  = out_sum;
    for (int k = 0; k < SLICES; k++) begin
      if (slice_idx == IDXW'(k)) sum_next[3*k +: 3] = slice_res[2:0];
    end
    last_slice = (slice_idx == IDXW'(SLICES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      busy      <= 1'b0;
      slice_idx <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a      <= in_a;
            op_b      <= in_sub ? ~in_b : in_b;
            carry     <= in_sub | in_cin;
            out_sum   <= '0;
            slice_idx <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          out_sum <= sum_next;
          carry   <= slice_res[3];
          if (last_slice) begin
            out_cout <= slice_res[3];
            // Effective-operand signs agree but the result sign differs.
            out_ovf  <= (op_a[W-1] == op_b[W-1]) & (sum_next[W-1] != op_a[W-1]);
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            slice_idx <= slice_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_serial_adder_ctrl.sv
// Bench for slice_serial_adder_ctrl: an arithmetic/cycle-count reference model checked
// every cycle, plus directed operations with hand-computed results.
module tb_slice_serial_adder_ctrl;

  localparam int SLICES = 4;
  localparam int IDXW   = 2;
  localparam int W      = 3 * SLICES;
  localparam int LAT    = SLICES + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_cin;
  logic           in_sub;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_sum;
  logic           out_cout;
  logic           out_ovf;
  logic           busy;
  logic [IDXW-1:0] slice_idx;

  int n_checks = 0;
  int n_err    = 0;

  slice_serial_adder_ctrl #(.SLICES(SLICES), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy), .slice_idx(slice_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_cnt counts edges since acceptance (0 = idle).
  int           m_cnt  = 0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;

  always @(posedge clk) begin
    int sa, sb, res, full;
    if (rst) begin
      m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (in_valid) begin
        sa = (int'(in_a) >= 2048) ? int'(in_a) - 4096 : int'(in_a);
        sb = (int'(in_b) >= 2048) ? int'(in_b) - 4096 : int'(in_b);
        if (in_sub) begin
          full = int'(in_a) - int'(in_b) + 4096;
          res  = sa - sb;
        end else begin
          full = int'(in_a) + int'(in_b) + int'(in_cin);
          res  = sa + sb + int'(in_cin);
        end
        m_sum  <= W'(full % 4096);
        m_cout <= (full >= 4096);
        m_ovf  <= (res > 2047) || (res < -2048);
        m_cnt  <= 1;
      end
    end else if (m_cnt < LAT + 1) begin
      m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_cnt == 0));
    chk("out_valid", 32'(out_valid), 32'(m_cnt == LAT + 1));
    chk("busy", 32'(busy), 32'(m_cnt >= 1 && m_cnt <= SLICES));
    if (m_cnt >= 1 && m_cnt <= SLICES) chk("slice_idx", 32'(slice_idx), 32'(m_cnt - 1));
    if (m_cnt == LAT + 1) begin
      chk("model_sum", 32'(out_sum), 32'(m_sum));
      chk("model_cout", 32'(out_cout), 32'(m_cout));
      chk("model_ovf", 32'(out_ovf), 32'(m_ovf));
    end
  end

  // Issue one operation, check latency and hand-computed result, optionally hold off
  // the consumer for `hold` cycles while a new request is pending.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic [W-1:0] es, input logic ec,
                       input logic eo, input int hold, input string name);
    int n;
    logic [W-1:0] held_sum;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({name, "_accept_wait"}, 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~cin; in_sub = ~sub;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, "_latency"}, 32'(n), 32'(LAT));
    chk({name, "_sum"}, 32'(out_sum), 32'(es));
    chk({name, "_cout"}, 32'(out_cout), 32'(ec));
    chk({name, "_ovf"}, 32'(out_ovf), 32'(eo));
    held_sum = out_sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
      @(posedge clk); #1;
      chk({name, "_hold_sum"}, 32'(out_sum), 32'(held_sum));
      chk({name, "_hold_ready"}, 32'(in_ready), 32'(0));
      chk({name, "_hold_valid"}, 32'(out_valid), 32'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_release_ready"}, 32'(in_ready), 32'(1));
    chk({name, "_release_valid"}, 32'(out_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_sum", 32'(out_sum), 32'(0));
    chk("reset_cout", 32'(out_cout), 32'(0));
    chk("reset_ovf", 32'(out_ovf), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_idx", 32'(slice_idx), 32'(0));
    @(posedge clk); #1;

    do_op(12'h5A3, 12'h1C7, 1'b0, 1'b0, 12'h76A, 1'b0, 1'b0, 0, "add");
    do_op(12'hFFF, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 0, "ripple");
    do_op(12'h005, 12'h007, 1'b1, 1'b1, 12'hFFE, 1'b0, 1'b0, 0, "sub_borrow");
    do_op(12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1, 0, "ovf_add");
    do_op(12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1, 0, "ovf_sub");
    do_op(12'hABC, 12'h123, 1'b1, 1'b0, 12'hBE0, 1'b0, 1'b0, 6, "backpressure");
    do_op(12'h123, 12'h456, 1'b0, 1'b1, 12'hCCD, 1'b0, 1'b0, 0, "after_bp");

    // Abort in the middle of RUN.
    in_a = 12'h321; in_b = 12'h654; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (slice_idx != 2'd2 && n < 10) begin @(posedge clk); #1; n++; end
    chk("midrun_idx_reached", 32'(slice_idx), 32'(2));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_in_ready", 32'(in_ready), 32'(1));
    chk("midrun_out_valid", 32'(out_valid), 32'(0));
    chk("midrun_sum", 32'(out_sum), 32'(0));
    chk("midrun_idx", 32'(slice_idx), 32'(0));
    chk("midrun_busy", 32'(busy), 32'(0));
    do_op(12'h001, 12'h001, 1'b0, 1'b0, 12'h002, 1'b0, 1'b0, 0, "post_reset");

    do_op(12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 0, "neg_ovf");
    do_op(12'h000, 12'h000, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 0, "zero_sub");

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
